// File: rtl/rom_reader_pkg.sv
// Shared constants and state encoding for the PROM dump sequencer.
// Chip-type codes, last-address limits and FSM state type live here.
package rom_reader_pkg;

  localparam logic CHIP_IP3601 = 1'b0;
  localparam logic CHIP_IP3604 = 1'b1;

  localparam int unsigned LAST_ADDR_IP3601 = 255;
  localparam int unsigned LAST_ADDR_IP3604 = 511;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_OUTPUT = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  function automatic int unsigned last_address(input logic chip);
    return (chip == CHIP_IP3604) ? LAST_ADDR_IP3604 : LAST_ADDR_IP3601;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counting settle timer: load arms it, count decrements, expired is
// the terminal-count compare. Loaded with CYCLES-1 so a wait spans CYCLES clocks.
module settle_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expired
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = 8'(CYCLES - 1);
    end else if (count && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == 8'd0);

endmodule

// File: rtl/rom_dump_sequencer.sv
// Walks every address of an IP3601 or IP3604 PROM and streams each word out
// over a valid/ready interface. All outputs are registered from next-state values.
//
// state  | meaning
// IDLE   | waiting for start; chip enables released
// SETUP  | drive address, assert selected chip enables, arm settle timer
// SETTLE | wait SETTLE_CYCLES for ROM data to settle
// SAMPLE | capture ROM data and address into output registers
// OUTPUT | present beat until out_ready; advance or finish
// DONE   | one-cycle done pulse
module rom_dump_sequencer
  import rom_reader_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ADDRESS_WIDTH = 9,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     chip_type,
  input  logic [DATA_WIDTH-1:0]    chip_data_port,
  output logic [ADDRESS_WIDTH-1:0] chip_address_port,
  output logic [1:0]               ip3601_selection_port,
  output logic [3:0]               ip3604_selection_port,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  state_e                   state_q, state_d;
  logic                     chip_q, chip_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] chip_addr_q, chip_addr_d;
  logic [1:0]               sel3601_q, sel3601_d;
  logic [3:0]               sel3604_q, sel3604_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [ADDRESS_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     timer_load, timer_count, timer_expired;
  logic                     en_active;
  logic [ADDRESS_WIDTH-1:0] last_addr;

  settle_timer #(.CYCLES(SETTLE_CYCLES)) u_settle_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .count   (timer_count),
    .expired (timer_expired)
  );

  assign last_addr = ADDRESS_WIDTH'(last_address(chip_q));

  always_comb begin
    state_d     = state_q;
    chip_d      = chip_q;
    addr_d      = addr_q;
    timer_load  = 1'b0;
    timer_count = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          chip_d  = chip_type;
          addr_d  = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        timer_load = 1'b1;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        timer_count = 1'b1;
        if (timer_expired) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: state_d = ST_OUTPUT;
      ST_OUTPUT: begin
        if (out_ready) begin
          if (addr_q == last_addr) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + ADDRESS_WIDTH'(1);
            state_d = ST_SETUP;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // abort drops any pending beat and skips the done pulse
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_comb begin
    en_active   = state_d inside {ST_SETUP, ST_SETTLE, ST_SAMPLE, ST_OUTPUT};
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    out_valid_d = (state_d == ST_OUTPUT);
    sel3601_d   = (en_active && (chip_d == CHIP_IP3601)) ? 2'b00 : 2'b11;
    sel3604_d   = (en_active && (chip_d == CHIP_IP3604)) ? 4'b0000 : 4'b1111;
    chip_addr_d = (state_d == ST_SETUP) ? addr_d : chip_addr_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    if (state_q == ST_SAMPLE) begin
      out_addr_d = addr_q;
      if (chip_q == CHIP_IP3601) begin
        out_data_d = {{(DATA_WIDTH-4){1'b0}}, chip_data_port[3:0]};
      end else begin
        out_data_d = chip_data_port;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      chip_q      <= CHIP_IP3601;
      addr_q      <= '0;
      chip_addr_q <= '0;
      sel3601_q   <= 2'b11;
      sel3604_q   <= 4'b1111;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chip_q      <= chip_d;
      addr_q      <= addr_d;
      chip_addr_q <= chip_addr_d;
      sel3601_q   <= sel3601_d;
      sel3604_q   <= sel3604_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign chip_address_port     = chip_addr_q;
  assign ip3601_selection_port = sel3601_q;
  assign ip3604_selection_port = sel3604_q;
  assign out_data              = out_data_q;
  assign out_address           = out_addr_q;
  assign out_valid             = out_valid_q;
  assign busy                  = busy_q;
  assign done                  = done_q;

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Bench for rom_dump_sequencer: ROM model on the chip bus, randomized out_ready,
// and a beat-timing reference model (one beat every SETTLE+3 cycles per handshake).
module tb_rom_dump_sequencer;

  localparam int S    = 4;
  localparam int STEP = S + 3;

  logic       clk = 1'b0;
  logic       reset, start, abort, chip_type, out_ready;
  logic [7:0] chip_data_port;
  logic [8:0] chip_address_port;
  logic [1:0] ip3601_selection_port;
  logic [3:0] ip3604_selection_port;
  logic [7:0] out_data;
  logic [8:0] out_address;
  logic       out_valid, busy, done;
  logic       rom_chip;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // IP3601 only drives the low nibble; the upper lines float to a junk value
  assign chip_data_port = rom_chip ? (chip_address_port[7:0] ^ 8'hA5)
                                   : {4'hA, chip_address_port[3:0] ^ 4'h5};

  rom_dump_sequencer #(.SETTLE_CYCLES(S), .ADDRESS_WIDTH(9), .DATA_WIDTH(8)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .abort                 (abort),
    .chip_type             (chip_type),
    .chip_data_port        (chip_data_port),
    .chip_address_port     (chip_address_port),
    .ip3601_selection_port (ip3601_selection_port),
    .ip3604_selection_port (ip3604_selection_port),
    .out_data              (out_data),
    .out_address           (out_address),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .busy                  (busy),
    .done                  (done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rom_word(input logic chip, input int a);
    if (chip) return 8'(a) ^ 8'hA5;
    return 8'((a ^ 5) & 'hF);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sel3601"}, ip3601_selection_port, 2'b11);
    chk({tag, "_sel3604"}, ip3604_selection_port, 4'hF);
  endtask

  // mode: 0 plain, 1 abort at beat 100, 2 start/chip_type disturbance, 3 reset at stalled beat 50
  task automatic run_scan(input logic chip, input int ready_pct, input int mode);
    int  n;
    int  idx;
    int  vcyc;
    int  done_cyc;
    int  cyc;
    int  post;
    bit  ended;
    bit  exp_valid;
    n        = chip ? 512 : 256;
    idx      = 0;
    vcyc     = STEP;
    done_cyc = 1 << 30;
    cyc      = 0;
    post     = 0;
    ended    = 0;
    rom_chip = chip;
    @(negedge clk);
    start     = 1'b1;
    chip_type = chip;
    abort     = 1'b0;
    out_ready = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (ended) begin
        check_idle(mode == 3 ? "rst" : "abort");
        if (mode == 3 && post == 0) begin
          chk("rst_out_data", out_data, 0);
          chk("rst_out_address", out_address, 0);
          chk("rst_chip_address", chip_address_port, 0);
        end
        reset = 1'b0;
        abort = 1'b0;
        post++;
        if (post == 3) break;
        continue;
      end
      exp_valid = (cyc >= vcyc) && (idx < n);
      chk("valid", out_valid, exp_valid);
      chk("done", done, cyc == done_cyc);
      chk("busy", busy, cyc <= done_cyc);
      chk("sel3601", ip3601_selection_port, (chip == 1'b0 && cyc < done_cyc) ? 2'b00 : 2'b11);
      chk("sel3604", ip3604_selection_port, (chip == 1'b1 && cyc < done_cyc) ? 4'h0 : 4'hF);
      if (exp_valid) begin
        chk("out_address", out_address, idx);
        chk("out_data", out_data, rom_word(chip, idx));
        chk("chip_address", chip_address_port, idx);
      end
      if (cyc > done_cyc + 2) break;
      if (cyc > 8000) begin
        chk("timeout", cyc, 0);
        break;
      end
      start     = (mode == 2 && cyc >= 100 && cyc < 120);
      chip_type = (mode == 2 && cyc >= 100 && cyc < 120) ? ~chip : chip;
      out_ready = ($urandom_range(99) < ready_pct);
      if (exp_valid && mode == 1 && idx == 100) begin
        abort     = 1'b1;
        out_ready = 1'b0;
        ended     = 1;
      end else if (exp_valid && mode == 3 && idx == 50) begin
        reset     = 1'b1;
        out_ready = 1'b0;
        ended     = 1;
      end else if (exp_valid && out_ready) begin
        idx++;
        vcyc = cyc + STEP;
        if (idx == n) done_cyc = cyc + 1;
      end
    end
    start     = 1'b0;
    chip_type = chip;
    if (mode == 0 || mode == 2) chk("beat_count", idx, n);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    chip_type = 1'b0;
    out_ready = 1'b0;
    rom_chip  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
    chk("reset_chip_address", chip_address_port, 0);

    run_scan(1'b0, 100, 0);
    run_scan(1'b1, 50, 0);
    run_scan(1'b1, 100, 1);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_idle("abort_start");
    @(negedge clk);
    check_idle("abort_start2");

    run_scan(1'b0, 100, 2);
    run_scan(1'b1, 30, 3);
    run_scan(1'b0, 100, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_dump_sequencer.md
ROM_DUMP_SEQUENCER -- requirements
Module: rom_dump_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, address-to-data settle wait in clk cycles (range 1..255).
REQ-002 Parameter ADDRESS_WIDTH, default 9, chip address bus width.
REQ-003 Parameter DATA_WIDTH, default 8, chip data bus width.
REQ-004 clk  input  1  board clock; the only clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a full dump; sampled only in IDLE.
REQ-007 abort  input  1  terminate the scan in progress.
REQ-008 chip_type  input  1  0 = IP3601 (256 x 4), 1 = IP3604 (512 x 8); latched on an accepted start.
REQ-009 chip_data_port  input  8  ROM data lines.
REQ-010 chip_address_port  output  9  ROM address lines.
REQ-011 ip3601_selection_port  output  2  IP3601 chip enables, active-low.
REQ-012 ip3604_selection_port  output  4  IP3604 chip enables, active-low.
REQ-013 out_data  output  8  sampled ROM word; for IP3601, [7:4] = 0.
REQ-014 out_address  output  9  address of out_data.
REQ-015 out_valid  output  1  out_data and out_address are valid.
REQ-016 out_ready  input  1  downstream accepts the beat.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse on scan completion.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, SETTLE, SAMPLE, OUTPUT and DONE.
REQ-020 IDLE: start=1 with abort=0 SHALL latch chip_type, clear the address to 0 and enter SETUP.
REQ-021 SETUP (1 cycle): chip_address_port SHALL be driven with the current address, the latched chip's enables SHALL be driven all-zero, and the FSM SHALL enter SETTLE.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter SAMPLE.
REQ-023 SAMPLE (1 cycle): chip_data_port SHALL be registered into out_data (IP3601: [3:0] only, [7:4] forced to 0) and the address into out_address; the FSM SHALL enter OUTPUT.
REQ-024 OUTPUT: out_valid=1; out_data and out_address SHALL stay stable until out_valid && out_ready.
REQ-025 On the OUTPUT handshake: if the address equals the last address (255 for IP3601, 511 for IP3604) the FSM SHALL enter DONE; otherwise address+1 and SETUP.
REQ-026 DONE (1 cycle): done=1, then IDLE.
REQ-027 The address counter SHALL never wrap; the last address always terminates the scan.
REQ-028 The selected chip's enables SHALL stay asserted from SETUP of address 0 through OUTPUT of the last address; the non-selected chip's enables SHALL stay all-ones throughout.
REQ-029 In IDLE and DONE, both enable ports SHALL be all-ones and out_valid SHALL be 0.
REQ-030 With out_ready held at 1: first out_valid SHALL occur SETTLE_CYCLES+3 cycles after start is sampled, and each beat SHALL take SETTLE_CYCLES+3 cycles.
REQ-031 start while busy SHALL be ignored; a chip_type change mid-scan SHALL be ignored.
REQ-032 abort=1 in any non-IDLE state SHALL enter IDLE on the next cycle with no done pulse; any pending beat SHALL be dropped.
REQ-033 abort and start together in IDLE: abort wins and the FSM stays in IDLE.

Reset
REQ-034 reset=1 at any clock edge, including mid-scan or during a stalled OUTPUT, SHALL force IDLE with: address 0, chip_address_port 0, out_data 0, out_address 0, out_valid 0, done 0, busy 0, ip3601_selection_port 2'b11, ip3604_selection_port 4'b1111, latched chip_type 0.
REQ-035 Reset SHALL take priority over start and abort.

Structure
REQ-036 The chip-type constants (IP3601=0, IP3604=1), the last-address constants (255, 511) and the FSM state encodings SHALL live in the shared package rom_reader_pkg.
REQ-037 The settle wait SHALL be implemented as a sub-module settle_timer (load/count/expired) instantiated once.
REQ-038 All outputs SHALL be registered.

Verification (SETTLE_CYCLES=4)
REQ-039 Reset then idle: after reset, chip_address_port=0, enables 2'b11/4'b1111, out_valid=0, busy=0, done=0.
REQ-040 IP3601 scan, out_ready=1, ROM model data=(addr^5)&0xF: 256 beats with addresses 0..255 in order, out_data[7:4]=0, first out_valid at cycle 7, done at cycle 1793 (start sampled at cycle 0), exactly once; ip3604_selection_port stays 4'b1111.
REQ-041 IP3604 scan, out_ready random at 50%, data=addr[7:0]^0xA5: 512 beats matching the model, data stable on every stall, no gaps or duplicates, done once.
REQ-042 Abort asserted while out_address=100 is in OUTPUT: IDLE on the next cycle, enables all-ones, out_valid=0, no done pulse.
REQ-043 start re-pulsed and chip_type toggled mid-scan: no restart, and the latched chip and beat count are unchanged.
REQ-044 reset during a stalled OUTPUT (out_ready=0): all REQ-034 values on the next cycle; a subsequent start scans from address 0.
